// File: rtl/multi_cycle_ctrl.sv
// -----------------------------------------------------------------------------
// multi_cycle_ctrl
//
// Main control FSM for the multi-cycle RV32I core. Each instruction is walked
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The FSM also selects the
// immediate format, raises the write strobes and mux selects for PC, IR,
// register file and data memory, and waits on instruction and data memory
// handshakes. If either memory stays silent too long, the FSM enters a sticky
// TRAP state.
//
// Optional feature macro: MULTI_CYCLE_CTRL_INSTRET_EN
//   defined   -> instret counts pc_we pulses (32-bit, wraps), cleared by reset
//   undefined -> instret is tied to zero
//
// Parameters:
//   MEM_TIMEOUT  max cycles spent waiting in FETCH or MEM (1..255)
//   CNT_W        wait counter width, 2**CNT_W > MEM_TIMEOUT
//
// Ports:
//   cpu_clk   in   clock, rising edge
//   cpu_rst   in   synchronous active-high reset
//   inst      in   IR contents (opcode in inst[6:0])
//   imem_rdy  in   instruction memory data valid
//   br_taken  in   branch comparison result, used in EXEC
//   dmem_ack  in   data memory access complete
//   imem_req  out  instruction fetch request
//   ir_we     out  IR load strobe
//   sext_op   out  immediate format 0=I 1=S 2=B 3=U 4=J
//   pc_we     out  PC update strobe
//   pc_sel    out  0=pc+4 1=pc+imm 2=ALU
//   rf_we     out  register file write strobe
//   wd_sel    out  0=ALU 1=load 2=pc+4 3=imm
//   dmem_req  out  data memory request
//   dmem_we   out  store qualifier
//   trap      out  sticky fault flag
//   instret   out  retired-instruction count
// -----------------------------------------------------------------------------
module multi_cycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] inst,
    input  logic        imem_rdy,
    input  logic        br_taken,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        ir_we,
    output logic [2:0]  sext_op,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wd_sel,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        trap,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       sext_reg, sext_dec;
    logic             opc_legal;
    logic [6:0]       opcode;
    logic             unused_inst;

    assign opcode      = inst[6:0];
    assign unused_inst = ^inst[31:7];

    // Opcode -> immediate format, plus legality check.
    always_comb begin
        sext_dec  = 3'd0;
        opc_legal = 1'b1;
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_OP: sext_dec = 3'd0;
            OPC_STORE:                             sext_dec = 3'd1;
            OPC_BRANCH:                            sext_dec = 3'd2;
            OPC_LUI, OPC_AUIPC:                    sext_dec = 3'd3;
            OPC_JAL:                               sext_dec = 3'd4;
            default:                               opc_legal = 1'b0;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_reg <= S_FETCH;
            cnt_reg   <= '0;
            sext_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == S_DECODE)
                sext_reg <= sext_dec;
        end
    end

    // Next state and strobes. The whole decode sits under !cpu_rst so every
    // strobe is forced low while reset is held, whatever state the FSM is in.
    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_sel     = 2'd0;
        rf_we      = 1'b0;
        wd_sel     = 2'd0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        if (!cpu_rst) begin
            case (state_reg)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_rdy) begin
                        ir_we      = 1'b1;
                        state_next = S_DECODE;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_next = S_TRAP;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                S_DECODE: begin
                    state_next = opc_legal ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    if (opcode == OPC_LOAD || opcode == OPC_STORE) begin
                        state_next = S_MEM;
                    end else if (opcode == OPC_BRANCH) begin
                        pc_we      = 1'b1;
                        pc_sel     = br_taken ? 2'd1 : 2'd0;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (opcode == OPC_STORE);
                    if (dmem_ack) begin
                        if (opcode == OPC_STORE) begin
                            // Stores retire here; they never visit WB.
                            pc_we      = 1'b1;
                            state_next = S_FETCH;
                        end else begin
                            state_next = S_WB;
                        end
                    end else if (cnt_reg == CNT_LAST) begin
                        state_next = S_TRAP;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                S_WB: begin
                    rf_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_next = S_FETCH;
                    case (opcode)
                        OPC_JAL:  begin pc_sel = 2'd1; wd_sel = 2'd2; end
                        OPC_JALR: begin pc_sel = 2'd2; wd_sel = 2'd2; end
                        OPC_LOAD: wd_sel = 2'd1;
                        OPC_LUI:  wd_sel = 2'd3;
                        default:  wd_sel = 2'd0;
                    endcase
                end
                default: state_next = S_TRAP;
            endcase
        end
    end

    assign sext_op = sext_reg;
    assign trap    = (state_reg == S_TRAP);

`ifdef MULTI_CYCLE_CTRL_INSTRET_EN
    logic [31:0] instret_reg;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst)
            instret_reg <= '0;
        else if (pc_we)
            instret_reg <= instret_reg + 32'd1;
    end

    assign instret = instret_reg;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic [31:0] inst = 32'h0;
    logic        imem_rdy = 1'b0;
    logic        br_taken = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, ir_we, pc_we, rf_we, dmem_req, dmem_we, trap;
    logic [2:0]  sext_op;
    logic [1:0]  pc_sel, wd_sel;
    logic [31:0] instret;

    int errors = 0;
    int checks = 0;

    multi_cycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(8)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .inst(inst),
        .imem_rdy(imem_rdy), .br_taken(br_taken), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .ir_we(ir_we), .sext_op(sext_op),
        .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we), .wd_sel(wd_sel),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .trap(trap),
        .instret(instret)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Strobe bundle: imem_req ir_we pc_we pc_sel rf_we wd_sel dmem_req dmem_we trap
    logic [10:0] strb;
    assign strb = {imem_req, ir_we, pc_we, pc_sel, rf_we, wd_sel, dmem_req, dmem_we, trap};

    function automatic logic [10:0] mk(input logic ireq, input logic irw, input logic pcw,
                                       input logic [1:0] ps, input logic rfw, input logic [1:0] wd,
                                       input logic dreq, input logic dwe, input logic tr);
        return {ireq, irw, pcw, ps, rfw, wd, dreq, dwe, tr};
    endfunction

    localparam logic [10:0] FR   = 11'b1_1_0_00_0_00_0_0_0;  // FETCH with imem_rdy
    localparam logic [10:0] FW   = 11'b1_0_0_00_0_00_0_0_0;  // FETCH waiting
    localparam logic [10:0] IDL  = 11'b0;                    // DECODE / EXEC non-branch
    localparam logic [10:0] TR   = 11'b0_0_0_00_0_00_0_0_1;
    localparam logic [10:0] MLD  = 11'b0_0_0_00_0_00_1_0_0;  // MEM, load
    localparam logic [10:0] MST  = 11'b0_0_0_00_0_00_1_1_0;  // MEM, store, no ack
    localparam logic [10:0] MSTA = 11'b0_0_1_00_0_00_1_1_0;  // MEM, store, ack

    localparam logic [31:0] I_ADDI = 32'h00500093;
    localparam logic [31:0] I_LW   = 32'h0000A103;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_BEQ  = 32'h00000463;
    localparam logic [31:0] I_JAL  = 32'h0000006F;
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    // Advance to the next falling edge, drive inputs, let comb logic settle.
    task automatic step(input logic rdy, input logic ack, input logic bt);
        @(negedge cpu_clk);
        imem_rdy = rdy;
        dmem_ack = ack;
        br_taken = bt;
        #1;
    endtask

    // Hold reset for two edges and release at a falling edge.
    task automatic apply_reset();
        @(negedge cpu_clk);
        cpu_rst = 1'b1; imem_rdy = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge cpu_clk);
        cpu_rst = 1'b1; imem_rdy = 1'b1; dmem_ack = 1'b1; br_taken = 1'b1;
        #1;
        checks++;
        if (strb !== IDL) begin errors++; $display("FAIL reset_hold strobes got=%b exp=%b", strb, IDL); end
        @(negedge cpu_clk);
        #1;
        checks++;
        if (strb !== IDL) begin errors++; $display("FAIL reset_hold2 strobes got=%b exp=%b", strb, IDL); end
        checks++;
        if (sext_op !== 3'd0) begin errors++; $display("FAIL reset_sext got=%0d exp=0", sext_op); end
        checks++;
        if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got=%0d exp=0", instret); end
        cpu_rst = 1'b0; imem_rdy = 1'b0; dmem_ack = 1'b0; br_taken = 1'b0;
        #1;
        checks++;
        if (strb !== FW) begin errors++; $display("FAIL reset_release strobes got=%b exp=%b", strb, FW); end
    endtask

    task automatic test_alu_addi();
        logic [10:0] exp [5];
        exp = '{FR, IDL, IDL, mk(0,0,1,2'd0,1,2'd0,0,0,0), FW};
        inst = I_ADDI;
        for (int c = 0; c < 5; c++) begin
            step(c < 2, 1'b0, 1'b0);   // imem_rdy in DECODE must be ignored
            checks++;
            if (strb !== exp[c]) begin errors++; $display("FAIL addi cyc%0d strobes got=%b exp=%b", c, strb, exp[c]); end
            if (c == 2) begin
                checks++;
                if (sext_op !== 3'd0) begin errors++; $display("FAIL addi_sext got=%0d exp=0", sext_op); end
            end
        end
    endtask

    task automatic test_load();
        logic [10:0] exp [9];
        exp = '{FR, IDL, IDL, MLD, MLD, MLD, MLD, mk(0,0,1,2'd0,1,2'd1,0,0,0), FW};
        inst = I_LW;
        for (int c = 0; c < 9; c++) begin
            step(c == 0, (c == 6) || (c == 1), 1'b0);  // ack in DECODE is ignored
            checks++;
            if (strb !== exp[c]) begin errors++; $display("FAIL load cyc%0d strobes got=%b exp=%b", c, strb, exp[c]); end
        end
    endtask

    task automatic test_branch();
        for (int run = 0; run < 2; run++) begin
            logic bt;
            logic [10:0] exp [4];
            bt = (run == 0);
            exp = '{FR, IDL, mk(0,0,1,(bt ? 2'd1 : 2'd0),0,2'd0,0,0,0), FW};
            inst = I_BEQ;
            for (int c = 0; c < 4; c++) begin
                step(c == 0, 1'b0, (c == 2) ? bt : ~bt);
                checks++;
                if (strb !== exp[c]) begin errors++; $display("FAIL beq%0d cyc%0d strobes got=%b exp=%b", run, c, strb, exp[c]); end
                if (c == 2) begin
                    checks++;
                    if (sext_op !== 3'd2) begin errors++; $display("FAIL beq_sext got=%0d exp=2", sext_op); end
                end
            end
        end
    endtask

    task automatic test_wb_formats();
        logic [31:0] ins [5];
        logic [2:0]  sx  [5];
        logic [1:0]  ps  [5];
        logic [1:0]  wd  [5];
        ins = '{32'h000000B7, 32'h0000006F, 32'h00000097, 32'h00008067, 32'h002081B3};
        sx  = '{3'd3, 3'd4, 3'd3, 3'd0, 3'd0};  // LUI JAL AUIPC JALR ADD
        ps  = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0};
        wd  = '{2'd3, 2'd2, 2'd0, 2'd2, 2'd0};
        for (int k = 0; k < 5; k++) begin
            inst = ins[k];
            for (int c = 0; c < 4; c++) begin
                logic [10:0] e;
                e = (c == 0) ? FR : (c < 3) ? IDL : mk(0,0,1,ps[k],1,wd[k],0,0,0);
                step(c == 0, 1'b0, 1'b0);
                checks++;
                if (strb !== e) begin errors++; $display("FAIL fmt%0d cyc%0d strobes got=%b exp=%b", k, c, strb, e); end
                if (c == 2) begin
                    checks++;
                    if (sext_op !== sx[k]) begin errors++; $display("FAIL fmt%0d_sext got=%0d exp=%0d", k, sext_op, sx[k]); end
                end
            end
        end
    endtask

    task automatic test_store_ok();
        logic [10:0] exp [5];
        exp = '{FR, IDL, IDL, MSTA, FW};
        inst = I_SW;
        for (int c = 0; c < 5; c++) begin
            step(c == 0, c == 3, 1'b0);
            checks++;
            if (strb !== exp[c]) begin errors++; $display("FAIL store cyc%0d strobes got=%b exp=%b", c, strb, exp[c]); end
            if (c == 2) begin
                checks++;
                if (sext_op !== 3'd1) begin errors++; $display("FAIL store_sext got=%0d exp=1", sext_op); end
            end
        end
    endtask

    task automatic test_illegal();
        inst = I_BAD;
        for (int c = 0; c < 6; c++) begin
            logic [10:0] e;
            e = (c == 0) ? FR : (c == 1) ? IDL : TR;
            step(1'b1, 1'b1, 1'b0);  // handshakes must not disturb TRAP
            checks++;
            if (strb !== e) begin errors++; $display("FAIL illegal cyc%0d strobes got=%b exp=%b", c, strb, e); end
        end
        apply_reset();
        checks++;
        if (strb !== FW) begin errors++; $display("FAIL illegal_reset strobes got=%b exp=%b", strb, FW); end
    endtask

    task automatic test_fetch_timeout();
        apply_reset();
        checks++;
        if (strb !== FW) begin errors++; $display("FAIL ftimeout cyc0 strobes got=%b exp=%b", strb, FW); end
        for (int c = 1; c <= 16; c++) begin
            logic [10:0] e;
            e = (c < 16) ? FW : TR;
            step(1'b0, 1'b0, 1'b0);
            checks++;
            if (strb !== e) begin errors++; $display("FAIL ftimeout cyc%0d strobes got=%b exp=%b", c, strb, e); end
        end
    endtask

    task automatic test_store_timeout();
        apply_reset();
        inst = I_SW;
        for (int c = 0; c < 21; c++) begin
            logic [10:0] e;
            e = (c == 0) ? FR : (c < 3) ? IDL : (c < 19) ? MST : TR;
            step(c == 0, 1'b0, 1'b0);
            checks++;
            if (strb !== e) begin errors++; $display("FAIL stimeout cyc%0d strobes got=%b exp=%b", c, strb, e); end
        end
        apply_reset();
    endtask

    task automatic test_reset_mid_mem_instret();
        logic [31:0] seq [3];
        logic [31:0] exp_cnt;
        apply_reset();
        inst = I_SW;
        for (int c = 0; c < 5; c++) begin
            logic [10:0] e;
            e = (c == 0) ? FR : (c < 3) ? IDL : MST;
            step(c == 0, 1'b0, 1'b0);
            checks++;
            if (strb !== e) begin errors++; $display("FAIL midmem cyc%0d strobes got=%b exp=%b", c, strb, e); end
        end
        @(negedge cpu_clk);
        cpu_rst = 1'b1;
        #1;
        checks++;
        if (strb !== IDL) begin errors++; $display("FAIL midmem_rst strobes got=%b exp=%b", strb, IDL); end
        @(negedge cpu_clk);
        cpu_rst = 1'b0;
        #1;
        checks++;
        if (strb !== FW) begin errors++; $display("FAIL midmem_after strobes got=%b exp=%b", strb, FW); end
        checks++;
        if (instret !== 32'd0) begin errors++; $display("FAIL midmem_instret got=%0d exp=0", instret); end
        // ADDI, taken BEQ, JAL: three retirements.
        seq = '{I_ADDI, I_BEQ, I_JAL};
        for (int k = 0; k < 3; k++) begin
            int n;
            inst = seq[k];
            n = (k == 1) ? 3 : 4;
            for (int c = 0; c < n; c++)
                step(c == 0, 1'b0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0);
`ifdef MULTI_CYCLE_CTRL_INSTRET_EN
        exp_cnt = 32'd3;
`else
        exp_cnt = 32'd0;
`endif
        checks++;
        if (instret !== exp_cnt) begin errors++; $display("FAIL instret got=%0d exp=%0d", instret, exp_cnt); end
        checks++;
        if (strb !== FW) begin errors++; $display("FAIL seq_end strobes got=%b exp=%b", strb, FW); end
    endtask

    initial begin
        test_reset();
        test_alu_addi();
        test_load();
        test_branch();
        test_wb_formats();
        test_store_ok();
        test_illegal();
        test_fetch_timeout();
        test_store_timeout();
        test_reset_mid_mem_instret();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
